// File: rtl/xu_alu_cmp_pipe.sv
// Two-stage valid/ready compare/trap unit: stage 1 latches borrow, signs, equality
// and lane mask of the effective operands; stage 2 forms the CR field and trap.
module xu_alu_cmp_pipe #(
    parameter int WIDTH  = 64,
    parameter int LANE_W = 8,
    parameter int TAG_W  = 6
) (
    input  logic                      nclk,
    input  logic                      nreset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic                      in_msb64,
    input  logic [4:0]                in_to,
    input  logic [WIDTH-1:0]          in_rs1,
    input  logic [WIDTH-1:0]          in_rs2,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_cr,
    output logic                      out_trap,
    output logic [WIDTH/LANE_W-1:0]   out_eqb_mask,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int LANES = WIDTH / LANE_W;

    logic                 mode32;
    logic [WIDTH-1:0]     a_eff;
    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       diff_u;
    logic [LANES-1:0]     lane_eq;
    logic                 s2_advance;

    logic                 s1_valid;
    logic                 s1_borrow;
    logic                 s1_rs1_sign;
    logic                 s1_rs2_sign;
    logic                 s1_eq;
    logic [LANES-1:0]     s1_mask;
    logic [1:0]           s1_op;
    logic [4:0]           s1_to;
    logic [TAG_W-1:0]     s1_tag;

    logic                 lt_s;
    logic                 gt_s;
    logic                 lt_u;
    logic                 gt_u;
    logic [2:0]           cr_next;
    logic                 trap_next;

    assign mode32     = (WIDTH > 32) && !in_msb64;
    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance || flush;

    // 32-bit mode compares only the low word, zero-filled above bit 31
    always_comb begin
        a_eff = in_rs1;
        b_eff = in_rs2;
        if (mode32) begin
            a_eff        = '0;
            b_eff        = '0;
            a_eff[31:0]  = in_rs1[31:0];
            b_eff[31:0]  = in_rs2[31:0];
        end
    end

    assign diff_u = {1'b0, a_eff} - {1'b0, b_eff};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam bit UPPER = (i * LANE_W) >= 32;
        assign lane_eq[i] = (a_eff[i*LANE_W +: LANE_W] == b_eff[i*LANE_W +: LANE_W])
                            && !(UPPER && mode32);
    end

    always_ff @(posedge nclk or negedge nreset) begin
        if (!nreset) begin
            s1_valid    <= 1'b0;
            s1_borrow   <= 1'b0;
            s1_rs1_sign <= 1'b0;
            s1_rs2_sign <= 1'b0;
            s1_eq       <= 1'b0;
            s1_mask     <= '0;
            s1_op       <= '0;
            s1_to       <= '0;
            s1_tag      <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (in_ready)
                s1_valid <= in_valid;
            if (in_valid && in_ready && !flush) begin
                s1_borrow   <= diff_u[WIDTH];
                s1_rs1_sign <= mode32 ? in_rs1[31] : in_rs1[WIDTH-1];
                s1_rs2_sign <= mode32 ? in_rs2[31] : in_rs2[WIDTH-1];
                s1_eq       <= (a_eff == b_eff);
                s1_mask     <= lane_eq;
                s1_op       <= in_op;
                s1_to       <= in_to;
                s1_tag      <= in_tag;
            end
        end
    end

    // Differing signs decide signed order directly, so extreme operands never overflow
    always_comb begin
        lt_s      = (s1_rs1_sign != s1_rs2_sign) ? s1_rs1_sign : s1_borrow;
        lt_u      = s1_borrow;
        gt_s      = !lt_s && !s1_eq;
        gt_u      = !lt_u && !s1_eq;
        cr_next   = {lt_s, gt_s, s1_eq};
        trap_next = 1'b0;
        case (s1_op)
            2'b01:   cr_next = {lt_u, gt_u, s1_eq};
            2'b10:   trap_next = |(s1_to & {lt_s, gt_s, s1_eq, lt_u, gt_u});
            2'b11:   cr_next = {1'b0, |s1_mask, 1'b0};
            default: cr_next = {lt_s, gt_s, s1_eq};
        endcase
    end

    always_ff @(posedge nclk or negedge nreset) begin
        if (!nreset) begin
            out_valid    <= 1'b0;
            out_cr       <= '0;
            out_trap     <= 1'b0;
            out_eqb_mask <= '0;
            out_tag      <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (s2_advance)
                out_valid <= s1_valid;
            if (s2_advance && s1_valid && !flush) begin
                out_cr       <= cr_next;
                out_trap     <= trap_next;
                out_eqb_mask <= s1_mask;
                out_tag      <= s1_tag;
            end
        end
    end

endmodule
